speed_divider_arbiter: RTL and testbench
========================================

SPEED_DIVIDER_ARBITER -- requirements
Module: speed_divider_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of requesters (0 = speed calculation, 1 = current loop, 2 = spare).
REQ-002 SHALL have parameter DATA_W, default 26, operand and quotient width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 64, maximum cycles allowed from div_start_out to div_done_in.
REQ-004 SHALL have port sys_clk, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid_in, input, N_REQ, per-requester 1-cycle request strobe.
REQ-007 SHALL have port req_dividend_in, input, N_REQ*DATA_W, packed dividends; requester k occupies bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port req_divisor_in, input, N_REQ*DATA_W, packed divisors with the same packing as REQ-007.
REQ-009 SHALL have port rsp_valid_out, output, N_REQ, one-hot 1-cycle result strobe.
REQ-010 SHALL have port rsp_quotient_out, output, DATA_W, shared result bus, qualified by rsp_valid_out.
REQ-011 SHALL have port req_overrun_out, output, N_REQ, 1-cycle pulse: a pending request was overwritten.
REQ-012 SHALL have port div_start_out, output, 1, 1-cycle start pulse to the shared sequential divider.
REQ-013 SHALL have ports div_dividend_out and div_divisor_out, output, DATA_W each, divider operands, held stable from start until done.
REQ-014 SHALL have ports div_done_in, input, 1, and div_quotient_in, input, DATA_W, the divider completion strobe and its quotient.
REQ-015 SHALL have port div_timeout_out, output, 1, 1-cycle pulse on divider timeout.
REQ-016 SHALL have port busy_out, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-017 SHALL latch operands into a per-requester pending slot on req_valid_in[k] and set pending[k].
REQ-018 SHALL, when req_valid_in[k] arrives while pending[k] is already set and slot k is not in service, overwrite the slot with the new operands and pulse req_overrun_out[k].
REQ-019 SHALL, when req_valid_in[k] arrives while slot k is in service, capture the request as a new pending entry, without overrun and without affecting the current service.
REQ-020 SHALL use FSM states IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE.
REQ-021 SHALL leave IDLE when any pending bit is set, selecting the winner round-robin starting at (last_grant+1) mod N_REQ; last_grant resets to N_REQ-1, so requester 0 wins first.
REQ-022 SHALL, in ISSUE, drive the winner's operands, assert div_start_out for exactly one cycle, clear pending[winner], and go to WAIT.
REQ-023 SHALL bypass the divider when the winner's divisor is 0: no div_start_out, quotient forced to all-ones, direct transition to RESPOND.
REQ-024 SHALL, in WAIT, capture div_quotient_in on div_done_in and go to RESPOND.
REQ-025 SHALL, if the WAIT counter reaches TIMEOUT_CYC first, pulse div_timeout_out, force the quotient to all-ones, and go to RESPOND.
REQ-026 SHALL ignore div_done_in outside WAIT.
REQ-027 SHALL, in RESPOND, drive rsp_quotient_out, pulse rsp_valid_out[winner] for one cycle, update last_grant, and return to IDLE.
REQ-028 SHALL give a latency from the request strobe to rsp_valid_out of 4 + D cycles for an idle arbiter, where D is the divider's done latency.
REQ-029 SHALL give a latency of 3 cycles for the divisor-0 bypass.
REQ-030 SHALL hold rsp_quotient_out at its last value between responses.

Reset
REQ-031 SHALL, on reset asserted at any rising edge, including mid-WAIT, clear all pending bits and return the FSM to IDLE.
REQ-032 SHALL, on reset, set last_grant to N_REQ-1 and zero all outputs (rsp_valid_out, rsp_quotient_out, req_overrun_out, div_start_out, div_dividend_out, div_divisor_out, div_timeout_out, busy_out).
REQ-033 SHALL discard a div_done_in arriving after reset.

Structure
REQ-034 SHALL take the FSM state encoding, the default values of N_REQ, DATA_W and TIMEOUT_CYC, and the requester index constants from the shared project parameter package.
REQ-035 SHALL place the round-robin winner selection in one sub-module, rr_pick_next (pending vector + last_grant -> winner index + any-pending flag, combinational).

Verification
REQ-036 SHALL verify the single request: req 0 with dividend 390625, divisor 125, divider model D=30 -> one div_start_out, then rsp_valid_out=001 and quotient 3125 at cycle 34.
REQ-037 SHALL verify the simultaneous requests: all three strobed in the same cycle -> service order 0,1,2, then a second burst is served 0,1,2 again, with no starvation.
REQ-038 SHALL verify divide by zero: req 1 with divisor 0 -> no div_start_out, rsp_valid_out=010, quotient 0x3FFFFFF after 3 cycles.
REQ-039 SHALL verify timeout: divider model never asserts done -> div_timeout_out after 64 WAIT cycles, then quotient 0x3FFFFFF and the next pending request is served.
REQ-040 SHALL verify overrun: req 2 strobed twice while req 0 is in service -> req_overrun_out=100 once, and the response uses the second operand pair.
REQ-041 SHALL verify reset mid-WAIT: reset for 1 cycle, then a late div_done_in -> no rsp_valid_out, busy_out=0, pending cleared.

Source files
------------

// File: rtl/speed_divider_arbiter_pkg.sv
// Shared parameters, requester indices and FSM encoding for the speed-loop
// divider arbiter.
package speed_divider_arbiter_pkg;

    localparam int N_REQ_DEFAULT       = 3;
    localparam int DATA_W_DEFAULT      = 26;
    localparam int TIMEOUT_CYC_DEFAULT = 64;

    localparam int REQ_SPEED   = 0;
    localparam int REQ_CURRENT = 1;
    localparam int REQ_SPARE   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } arb_state_t;

    // Index width that stays legal for a single-requester build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/speed_divider_arbiter_rr_pick_next.sv
// Combinational round-robin pick: first pending requester after last_grant,
// wrapping modulo N_REQ.
module rr_pick_next
    import speed_divider_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] pending,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] winner,
    output logic             any_pending
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest pending requester wins.
    always_comb begin
        winner      = '0;
        cand        = '0;
        any_pending = |pending;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(last_grant) + i) % N_REQ);
            if (pending[cand]) begin
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/speed_divider_arbiter.sv
// Shares one sequential divider among the speed, current-loop and spare
// requesters, with per-requester pending slots and a done timeout.
module speed_divider_arbiter
    import speed_divider_arbiter_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEFAULT,
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                      sys_clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid_in,
    input  logic [N_REQ*DATA_W-1:0]   req_dividend_in,
    input  logic [N_REQ*DATA_W-1:0]   req_divisor_in,
    output logic [N_REQ-1:0]          rsp_valid_out,
    output logic [DATA_W-1:0]         rsp_quotient_out,
    output logic [N_REQ-1:0]          req_overrun_out,
    output logic                      div_start_out,
    output logic [DATA_W-1:0]         div_dividend_out,
    output logic [DATA_W-1:0]         div_divisor_out,
    input  logic                      div_done_in,
    input  logic [DATA_W-1:0]         div_quotient_in,
    output logic                      div_timeout_out,
    output logic                      busy_out
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [N_REQ-1:0]  pending;
    logic [N_REQ-1:0]  in_service;
    logic [DATA_W-1:0] slot_dividend [N_REQ];
    logic [DATA_W-1:0] slot_divisor  [N_REQ];
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  pick;
    logic              any_pending;
    logic [CNT_W-1:0]  wait_cnt;
    logic              start_issue;
    logic              bypass;
    logic              capture_done;
    logic              timeout_hit;

    rr_pick_next #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .pending     (pending),
        .last_grant  (last_grant),
        .winner      (pick),
        .any_pending (any_pending)
    );

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // rsp_valid_out is decoded from RESPOND so the divisor-0 path answers in 3
    // cycles while the divider path costs 4 + D.
    always_comb begin
        state_next    = state;
        start_issue   = 1'b0;
        bypass        = 1'b0;
        capture_done  = 1'b0;
        timeout_hit   = 1'b0;
        busy_out      = (state != ST_IDLE);
        rsp_valid_out = '0;
        in_service    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            in_service[k] = (state != ST_IDLE) && (winner == IDX_W'(k));
        end
        unique case (state)
            ST_IDLE: begin
                if (any_pending) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (slot_divisor[winner] == '0) begin
                    bypass     = 1'b1;
                    state_next = ST_RESPOND;
                end else begin
                    start_issue = 1'b1;
                    state_next  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (div_done_in) begin
                    capture_done = 1'b1;
                    state_next   = ST_RESPOND;
                end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                rsp_valid_out = N_REQ'(1) << winner;
                state_next    = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand slots are plain data storage; pending bits say whether they are live.
    always_ff @(posedge sys_clk) begin
        for (int k = 0; k < N_REQ; k++) begin
            if (req_valid_in[k]) begin
                slot_dividend[k] <= req_dividend_in[k*DATA_W +: DATA_W];
                slot_divisor[k]  <= req_divisor_in[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            pending          <= '0;
            last_grant       <= IDX_W'(N_REQ - 1);
            winner           <= '0;
            wait_cnt         <= '0;
            div_start_out    <= 1'b0;
            div_dividend_out <= '0;
            div_divisor_out  <= '0;
            div_timeout_out  <= 1'b0;
            rsp_quotient_out <= '0;
            req_overrun_out  <= '0;
        end else begin
            div_start_out   <= start_issue;
            div_timeout_out <= timeout_hit;

            if (state == ST_IDLE && any_pending) begin
                winner <= pick;
            end
            if (start_issue) begin
                div_dividend_out <= slot_dividend[winner];
                div_divisor_out  <= slot_divisor[winner];
            end
            if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (bypass || timeout_hit) begin
                rsp_quotient_out <= '1;
            end else if (capture_done) begin
                rsp_quotient_out <= div_quotient_in;
            end
            if (state == ST_RESPOND) begin
                last_grant <= winner;
            end

            // A fresh strobe beats the ISSUE clear, so a request landing while
            // its own slot is in service survives as the next pending entry.
            for (int k = 0; k < N_REQ; k++) begin
                req_overrun_out[k] <= req_valid_in[k] && pending[k] && !in_service[k];
                if (req_valid_in[k]) begin
                    pending[k] <= 1'b1;
                end else if (state == ST_ISSUE && winner == IDX_W'(k)) begin
                    pending[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_speed_divider_arbiter.sv
// Directed bench for speed_divider_arbiter with a behavioural divider of
// programmable done latency.
module tb_speed_divider_arbiter;

    localparam int N_REQ       = 3;
    localparam int DATA_W      = 26;
    localparam int TIMEOUT_CYC = 64;

    logic                    sys_clk = 1'b0;
    logic                    reset   = 1'b1;
    logic [N_REQ-1:0]        req_valid_in = '0;
    logic [N_REQ*DATA_W-1:0] req_dividend_in = '0;
    logic [N_REQ*DATA_W-1:0] req_divisor_in = '0;
    logic [N_REQ-1:0]        rsp_valid_out;
    logic [DATA_W-1:0]       rsp_quotient_out;
    logic [N_REQ-1:0]        req_overrun_out;
    logic                    div_start_out;
    logic [DATA_W-1:0]       div_dividend_out;
    logic [DATA_W-1:0]       div_divisor_out;
    logic                    div_done_in;
    logic [DATA_W-1:0]       div_quotient_in;
    logic                    div_timeout_out;
    logic                    busy_out;

    int checks = 0;
    int errors = 0;

    speed_divider_arbiter #(
        .N_REQ       (N_REQ),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .sys_clk          (sys_clk),
        .reset            (reset),
        .req_valid_in     (req_valid_in),
        .req_dividend_in  (req_dividend_in),
        .req_divisor_in   (req_divisor_in),
        .rsp_valid_out    (rsp_valid_out),
        .rsp_quotient_out (rsp_quotient_out),
        .req_overrun_out  (req_overrun_out),
        .div_start_out    (div_start_out),
        .div_dividend_out (div_dividend_out),
        .div_divisor_out  (div_divisor_out),
        .div_done_in      (div_done_in),
        .div_quotient_in  (div_quotient_in),
        .div_timeout_out  (div_timeout_out),
        .busy_out         (busy_out)
    );

    always #5 sys_clk = ~sys_clk;

    // Divider model: done is high D cycles after the cycle carrying the start pulse.
    int                div_latency = 30;
    logic              div_never = 1'b0;
    int                dcnt = 0;
    logic [DATA_W-1:0] dq = '0;

    always @(posedge sys_clk) begin
        if (div_start_out) begin
            dcnt <= div_latency;
            dq   <= (div_divisor_out != '0) ? div_dividend_out / div_divisor_out : '1;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
        end
    end

    assign div_done_in     = !div_never && (dcnt == 1);
    assign div_quotient_in = dq;

    int               n_start = 0;
    int               n_overrun = 0;
    int               n_timeout = 0;
    logic [N_REQ-1:0] last_overrun = '0;

    always @(negedge sys_clk) begin
        if (div_start_out) n_start++;
        if (div_timeout_out) n_timeout++;
        if (req_overrun_out != '0) begin
            n_overrun++;
            last_overrun = req_overrun_out;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic setOperands(input int k, input logic [DATA_W-1:0] dvd, input logic [DATA_W-1:0] dvs);
        req_dividend_in[k*DATA_W +: DATA_W] = dvd;
        req_divisor_in[k*DATA_W +: DATA_W]  = dvs;
    endtask

    // Called on a negedge: strobe for one cycle, return on the following negedge.
    task automatic applyStimulus(input logic [N_REQ-1:0] mask);
        req_valid_in = mask;
        @(negedge sys_clk);
        req_valid_in = '0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic waitResponse(input int budget, output logic [N_REQ-1:0] v,
                                output logic [DATA_W-1:0] q, output int cyc);
        bit found;
        found = 1'b0;
        cyc   = 0;
        v     = '0;
        q     = '0;
        while (!found && cyc < budget) begin
            if (rsp_valid_out != '0) begin
                v     = rsp_valid_out;
                q     = rsp_quotient_out;
                found = 1'b1;
            end else begin
                @(negedge sys_clk);
                cyc++;
            end
        end
    endtask

    logic [N_REQ-1:0]  v;
    logic [DATA_W-1:0] q;
    int                cyc;
    int                base;
    int                rsp_seen;
    int                busy_seen;

    initial begin
        idleCycles(3);
        checkOutput("rst_rsp_valid", 32'(rsp_valid_out), 32'h0);
        checkOutput("rst_rsp_quotient", 32'(rsp_quotient_out), 32'h0);
        checkOutput("rst_overrun", 32'(req_overrun_out), 32'h0);
        checkOutput("rst_div_start", 32'(div_start_out), 32'h0);
        checkOutput("rst_div_dividend", 32'(div_dividend_out), 32'h0);
        checkOutput("rst_div_divisor", 32'(div_divisor_out), 32'h0);
        checkOutput("rst_timeout", 32'(div_timeout_out), 32'h0);
        checkOutput("rst_busy", 32'(busy_out), 32'h0);
        reset = 1'b0;
        idleCycles(1);

        // Simultaneous bursts: order 0,1,2 twice.
        div_latency = 3;
        setOperands(0, 26'd100, 26'd10);
        setOperands(1, 26'd200, 26'd10);
        setOperands(2, 26'd300, 26'd10);
        applyStimulus(3'b111);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                waitResponse(200, v, q, cyc);
                checkOutput($sformatf("burst%0d_grant%0d", r, i), 32'(v), 32'(1 << i));
                checkOutput($sformatf("burst%0d_quot%0d", r, i), 32'(q), 32'((i + 1) * 10));
                idleCycles(1);
            end
            if (r == 0) applyStimulus(3'b111);
        end
        idleCycles(2);

        // Single request, D = 30: response 34 cycles after the strobe.
        div_latency = 30;
        setOperands(0, 26'd390625, 26'd125);
        base = n_start;
        applyStimulus(3'b001);
        waitResponse(100, v, q, cyc);
        checkOutput("single_latency", 32'(cyc + 1), 32'd34);
        checkOutput("single_grant", 32'(v), 32'h1);
        checkOutput("single_quot", 32'(q), 32'd3125);
        idleCycles(1);
        checkOutput("single_starts", 32'(n_start - base), 32'd1);
        checkOutput("single_valid_drop", 32'(rsp_valid_out), 32'h0);
        checkOutput("single_quot_hold", 32'(rsp_quotient_out), 32'd3125);
        checkOutput("single_idle", 32'(busy_out), 32'h0);
        idleCycles(2);

        // Divide by zero bypass on requester 1.
        setOperands(1, 26'd1234, 26'd0);
        base = n_start;
        applyStimulus(3'b010);
        waitResponse(20, v, q, cyc);
        checkOutput("div0_latency", 32'(cyc + 1), 32'd3);
        checkOutput("div0_grant", 32'(v), 32'h2);
        checkOutput("div0_quot", 32'(q), 32'h3FFFFFF);
        idleCycles(1);
        checkOutput("div0_no_start", 32'(n_start - base), 32'd0);
        idleCycles(2);

        // Timeout on requester 0, requester 1 queued behind it.
        div_never = 1'b1;
        setOperands(0, 26'd500, 26'd5);
        setOperands(1, 26'd600, 26'd6);
        base = n_timeout;
        applyStimulus(3'b001);
        applyStimulus(3'b010);
        waitResponse(150, v, q, cyc);
        checkOutput("tmo_latency", 32'(cyc + 2), 32'd67);
        checkOutput("tmo_grant", 32'(v), 32'h1);
        checkOutput("tmo_quot", 32'(q), 32'h3FFFFFF);
        checkOutput("tmo_pulse", 32'(div_timeout_out), 32'h1);
        div_never = 1'b0;
        idleCycles(1);
        checkOutput("tmo_count", 32'(n_timeout - base), 32'd1);
        waitResponse(100, v, q, cyc);
        checkOutput("tmo_next_grant", 32'(v), 32'h2);
        checkOutput("tmo_next_quot", 32'(q), 32'd100);
        idleCycles(2);

        // Overrun: requester 2 strobed twice while requester 0 is in WAIT.
        div_latency = 10;
        setOperands(0, 26'd1000, 26'd10);
        base = n_overrun;
        applyStimulus(3'b001);
        idleCycles(3);
        setOperands(2, 26'd900, 26'd3);
        applyStimulus(3'b100);
        idleCycles(1);
        setOperands(2, 26'd800, 26'd4);
        applyStimulus(3'b100);
        waitResponse(100, v, q, cyc);
        checkOutput("ovr_first_grant", 32'(v), 32'h1);
        checkOutput("ovr_first_quot", 32'(q), 32'd100);
        idleCycles(1);
        waitResponse(100, v, q, cyc);
        checkOutput("ovr_second_grant", 32'(v), 32'h4);
        checkOutput("ovr_second_quot", 32'(q), 32'd200);
        idleCycles(1);
        checkOutput("ovr_count", 32'(n_overrun - base), 32'd1);
        checkOutput("ovr_vector", 32'(last_overrun), 32'h4);
        idleCycles(2);

        // Reset mid-WAIT with requester 1 pending; the late done must be ignored.
        div_latency = 30;
        setOperands(0, 26'd10, 26'd2);
        setOperands(1, 26'd20, 26'd2);
        base = n_start;
        applyStimulus(3'b001);
        applyStimulus(3'b010);
        idleCycles(8);
        checkOutput("rstw_busy_before", 32'(busy_out), 32'h1);
        reset = 1'b1;
        idleCycles(1);
        reset = 1'b0;
        rsp_seen  = 0;
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid_out != '0) rsp_seen++;
            if (busy_out) busy_seen++;
            idleCycles(1);
        end
        checkOutput("rstw_no_rsp", 32'(rsp_seen), 32'd0);
        checkOutput("rstw_no_busy", 32'(busy_seen), 32'd0);
        checkOutput("rstw_starts", 32'(n_start - base), 32'd1);
        checkOutput("rstw_quot_zero", 32'(rsp_quotient_out), 32'h0);
        checkOutput("rstw_dividend_zero", 32'(div_dividend_out), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
